// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte queue feeding the UART transmit/tx_byte handshake
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int GUARD = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [7:0]    wr_byte,
  input  logic          clr_ovf,
  input  logic          flush,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic [7:0]    tx_byte,
  output logic          transmit,
  input  logic          is_transmitting
);

  localparam int              GW         = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam logic [AW:0]     DEPTH_C    = (AW + 1)'(DEPTH);
  localparam logic [GW-1:0]   GUARD_LAST = GW'(GUARD - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [7:0]      mem [DEPTH];
  logic [7:0]      rd_data;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [GW-1:0]   guard_cnt;

  logic            push;
  logic            drop;
  logic            pop;
  logic            load_tx;
  logic            guard_inc;

  // Occupancy flags come straight from the count register.
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // A flush swallows any same-cycle write, so it neither stores nor counts as a drop.
  // full is the registered value, so a pop in the same cycle cannot make room.
  assign push = wr && !full && !flush;
  assign drop = wr &&  full && !flush;

  // Next-state logic; pops are only issued from IDLE and never alongside a flush.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load_tx   = 1'b0;
    guard_inc = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !is_transmitting && !flush) begin
          pop       = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        load_tx   = 1'b1;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (is_transmitting) begin
          state_nxt = WAIT_DONE;
        end else if (guard_cnt == GUARD_LAST) begin
          // UART never acknowledged the pulse; give up rather than lock up.
          state_nxt = IDLE;
        end else begin
          guard_inc = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!is_transmitting) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset abandons any handshake in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Byte storage write port; no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_byte;
    end
  end

  // Registered read port, loaded on the pop and consumed in FETCH.
  always_ff @(posedge clk) begin
    if (pop) begin
      rd_data <= mem[rd_ptr];
    end
  end

  // Pointers and occupancy; a flush collapses the queue onto the read pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (flush) begin
        wr_ptr <= rd_ptr;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // UART-facing outputs: one-cycle transmit pulse, tx_byte held until the next fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      transmit <= 1'b0;
      tx_byte  <= 8'h00;
    end else begin
      transmit <= load_tx;
      if (load_tx) begin
        tx_byte <= rd_data;
      end
    end
  end

  // Watchdog for the transmit acknowledge, restarted on every fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      guard_cnt <= '0;
    end else if (load_tx) begin
      guard_cnt <= '0;
    end else if (guard_inc) begin
      guard_cnt <= guard_cnt + 1'b1;
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] wr_byte = 8'h00;
  logic       clr_ovf = 1'b0;
  logic       flush = 1'b0;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic [7:0] tx_byte;
  logic       transmit;
  logic       is_transmitting;

  logic       force_busy = 1'b0;
  logic       model_busy = 1'b0;
  int         busy_len = 100;
  logic       stuck0 = 1'b0;
  int         busy_left = 0;
  int         pulses = 0;
  logic [7:0] rx_q [$];

  int total = 0;
  int bad = 0;
  int p0;
  int qs;
  int n;

  assign is_transmitting = force_busy | model_busy;

  uart_tx_fifo #(.DEPTH(16), .AW(4), .GUARD(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .wr              (wr),
    .wr_byte         (wr_byte),
    .clr_ovf         (clr_ovf),
    .flush           (flush),
    .full            (full),
    .empty           (empty),
    .count           (count),
    .overflow        (overflow),
    .tx_byte         (tx_byte),
    .transmit        (transmit),
    .is_transmitting (is_transmitting)
  );

  always #5 clk = ~clk;

  // UART model: records each pulse, then stays busy for busy_len cycles unless stuck low.
  always @(negedge clk) begin
    if (transmit === 1'b1) begin
      rx_q.push_back(tx_byte);
      pulses = pulses + 1;
      if (!stuck0) begin
        model_busy = 1'b1;
        busy_left  = busy_len;
      end
    end else if (busy_left > 0) begin
      busy_left = busy_left - 1;
      if (busy_left == 0) model_busy = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  task automatic wait_rx(input int target, input int limit);
    n = 0;
    while (rx_q.size() < target && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst_transmit", 32'(transmit), 32'd0);
    chk("rst_tx_byte",  32'(tx_byte),  32'h00);
    chk("rst_count",    32'(count),    32'd0);
    chk("rst_empty",    32'(empty),    32'd1);
    chk("rst_full",     32'(full),     32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single byte: push at E0, pop at E1, transmit E2..E3
    p0 = pulses;
    @(negedge clk); wr = 1'b1; wr_byte = 8'hA5;
    @(negedge clk); wr = 1'b0;
    chk("sb_e0_transmit", 32'(transmit), 32'd0);
    chk("sb_e0_count",    32'(count),    32'd1);
    @(negedge clk);
    chk("sb_e1_transmit", 32'(transmit), 32'd0);
    chk("sb_e1_count",    32'(count),    32'd0);
    @(negedge clk);
    chk("sb_e2_transmit", 32'(transmit), 32'd1);
    chk("sb_e2_tx_byte",  32'(tx_byte),  32'hA5);
    @(negedge clk);
    chk("sb_e3_transmit", 32'(transmit), 32'd0);
    repeat (110) @(negedge clk);
    chk("sb_pulses",  32'(pulses - p0), 32'd1);
    chk("sb_count",   32'(count),       32'd0);
    chk("sb_hold",    32'(tx_byte),     32'hA5);

    // Burst of 16 with a 50-cycle UART: first pop precedes the last push, all 16 accepted
    busy_len = 50;
    qs = rx_q.size();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); wr = 1'b1; wr_byte = 8'(i + 1);
    end
    @(negedge clk); wr = 1'b0;
    chk("burst_count",    32'(count),    32'd15);
    chk("burst_overflow", 32'(overflow), 32'd0);
    wait_rx(qs + 16, 1500);
    repeat (5) @(negedge clk);
    chk("burst_n", 32'(rx_q.size() - qs), 32'd16);
    for (int i = 0; i < 16; i++) chk("burst_order", 32'(rx_q[qs + i]), 32'(i + 1));
    chk("burst_ovf_end", 32'(overflow), 32'd0);
    repeat (60) @(negedge clk);
    chk("burst_empty", 32'(empty), 32'd1);

    // Overflow: UART held busy, 17 pushes
    force_busy = 1'b1; busy_len = 3;
    @(negedge clk);
    qs = rx_q.size(); p0 = pulses;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i == 16) begin
        chk("ovf_full16",  32'(full),     32'd1);
        chk("ovf_count16", 32'(count),    32'd16);
        chk("ovf_flag16",  32'(overflow), 32'd0);
      end
      wr = 1'b1; wr_byte = 8'(8'h20 + i);
    end
    @(negedge clk); wr = 1'b0;
    chk("ovf_flag17",  32'(overflow), 32'd1);
    chk("ovf_count17", 32'(count),    32'd16);
    clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);
    force_busy = 1'b0;
    wait_rx(qs + 16, 600);
    repeat (40) @(negedge clk);
    chk("ovf_emitted", 32'(pulses - p0), 32'd16);
    for (int i = 0; i < 16; i++) chk("ovf_order", 32'(rx_q[qs + i]), 32'(8'h20 + i));

    // Simultaneous push/pop at count 3, then wrap index 15->0
    force_busy = 1'b1;
    @(negedge clk);
    qs = rx_q.size();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); wr = 1'b1; wr_byte = 8'(8'h40 + i);
    end
    @(negedge clk); force_busy = 1'b0; wr_byte = 8'h43;
    for (int i = 4; i < 16; i++) begin
      @(negedge clk);
      if (i == 4) chk("pp_count", 32'(count), 32'd3);
      wr_byte = 8'(8'h40 + i);
    end
    @(negedge clk); wr = 1'b0;
    wait_rx(qs + 16, 600);
    repeat (20) @(negedge clk);
    chk("wrap_n", 32'(rx_q.size() - qs), 32'd16);
    for (int i = 0; i < 16; i++) chk("wrap_order", 32'(rx_q[qs + i]), 32'(8'h40 + i));
    chk("wrap_overflow", 32'(overflow), 32'd0);

    // Guard: UART never raises busy; next byte goes after GUARD cycles
    stuck0 = 1'b1; p0 = pulses;
    @(negedge clk); wr = 1'b1; wr_byte = 8'h61;
    @(negedge clk); wr_byte = 8'h62;
    @(negedge clk); wr = 1'b0;
    @(negedge clk);
    chk("guard_first_transmit", 32'(transmit), 32'd1);
    chk("guard_first_byte",     32'(tx_byte),  32'h61);
    repeat (5) @(negedge clk);
    chk("guard_gap", 32'(transmit), 32'd0);
    @(negedge clk);
    chk("guard_second_transmit", 32'(transmit), 32'd1);
    chk("guard_second_byte",     32'(tx_byte),  32'h62);
    chk("guard_count",           32'(count),    32'd0);
    repeat (20) @(negedge clk);
    chk("guard_pulses", 32'(pulses - p0), 32'd2);

    // Flush with 5 queued; same-cycle write is discarded
    force_busy = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); wr = 1'b1; wr_byte = 8'(8'h71 + i);
    end
    @(negedge clk); wr = 1'b0;
    chk("flush_pre_count", 32'(count), 32'd5);
    flush = 1'b1; wr = 1'b1; wr_byte = 8'h76;
    @(negedge clk); flush = 1'b0; wr = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    force_busy = 1'b0; p0 = pulses;
    repeat (30) @(negedge clk);
    chk("flush_no_pulse", 32'(pulses - p0), 32'd0);
    @(negedge clk); wr = 1'b1; wr_byte = 8'h77;
    @(negedge clk); wr = 1'b0;
    repeat (15) @(negedge clk);
    chk("flush_after_pulse", 32'(pulses - p0), 32'd1);
    chk("flush_after_byte",  32'(rx_q[rx_q.size() - 1]), 32'h77);

    // Reset mid-frame with a full queue and overflow set
    stuck0 = 1'b0; busy_len = 20; force_busy = 1'b1;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk); wr = 1'b1; wr_byte = 8'(8'h80 + i);
    end
    @(negedge clk); wr = 1'b0;
    chk("mr_overflow", 32'(overflow), 32'd1);
    force_busy = 1'b0;
    n = 0;
    while (transmit !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mr_pulse_seen", 32'(transmit), 32'd1);
    chk("mr_pulse_byte", 32'(tx_byte),  32'h80);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mr_transmit", 32'(transmit), 32'd0);
    chk("mr_tx_byte",  32'(tx_byte),  32'h00);
    chk("mr_count",    32'(count),    32'd0);
    chk("mr_empty",    32'(empty),    32'd1);
    chk("mr_full",     32'(full),     32'd0);
    chk("mr_overflow_clr", 32'(overflow), 32'd0);
    @(negedge clk); rst = 1'b0;
    p0 = pulses;
    repeat (40) @(negedge clk);
    chk("mr_no_pulse", 32'(pulses - p0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
